pe_feeder: RTL and testbench

- Drives the input edge of the PE chain: weight-load stream (`wwrite`/`win`), activation stream (`active`/`datain`) and partial-sum seed (`sumin`).
- Sources weights and activations from two valid/ready streams; sequences one tile per `start` pulse (load weights, then stream activations, then drain).
- Sits between the tile buffers and the first PE of a column.

---
 rtl/pe_feeder_pkg.sv | 18 +
 rtl/pe_feeder.sv | 113 +++++++++++
 tb/tb_pe_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder shared types and widths.
// Imported by the PE-chain input feeder.
package pe_feeder_pkg;

  localparam int PE_DW  = 8;
  localparam int PE_SW  = 16;
  localparam int NVEC_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } feeder_state_t;

endpackage

// File: rtl/pe_feeder.sv
// Feeds one PE column: loads DEPTH weights, streams
// activations, then drains in-flight sums.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NVEC  = 64,
  parameter int DW    = PE_DW,
  parameter int SW    = PE_SW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NVEC_W-1:0] nvec,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DW-1:0]     w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DW-1:0]     a_data,
  output logic              wwrite,
  output logic [DW-1:0]     win,
  output logic              active,
  output logic [DW-1:0]     datain,
  output logic [SW-1:0]     sumin,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [NVEC_W-1:0] NMAX = NVEC_W'(NVEC);

  feeder_state_t state, nxt;

  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     dcnt;
  logic [NVEC_W-1:0] acnt;
  logic [NVEC_W-1:0] acnt_nx;
  logic [NVEC_W-1:0] nvec_q;
  logic              wfire;
  logic              afire;

  assign acnt_nx = acnt + NVEC_W'(1);
  assign wfire   = w_valid && w_ready;
  assign afire   = a_valid && a_ready;
  assign sumin   = '0;

  always_comb begin
    nxt     = state;
    w_ready = 1'b0;
    a_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && wcnt == LAST) nxt = S_GAP;
      end
      S_GAP: begin
        nxt = (nvec_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        a_ready = 1'b1;
        if (a_valid && acnt_nx == nvec_q) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt == LAST) nxt = S_DONE;
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      dcnt   <= '0;
      acnt   <= '0;
      nvec_q <= '0;
      wwrite <= 1'b0;
      win    <= '0;
      active <= 1'b0;
      datain <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nxt;
      wwrite <= wfire;
      active <= afire;
      busy   <= (nxt != S_IDLE);
      done   <= (nxt == S_DONE);
      if (wfire) win <= w_data;
      if (afire) datain <= a_data;
      if (state == S_IDLE && start) begin
        nvec_q <= (nvec > NMAX) ? NMAX : nvec;
        wcnt   <= '0;
        acnt   <= '0;
        dcnt   <= '0;
      end
      if (wfire) wcnt <= wcnt + CW'(1);
      if (afire) acnt <= acnt_nx;
      if (state == S_DRAIN) dcnt <= dcnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder.
// Checks tile sequencing, bubbles, clamping and reset.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NVEC_W-1:0] nvec;
  logic              w_valid;
  logic              w_ready;
  logic [7:0]        w_data;
  logic              a_valid;
  logic              a_ready;
  logic [7:0]        a_data;
  logic              wwrite;
  logic [7:0]        win;
  logic              active;
  logic [7:0]        datain;
  logic [15:0]       sumin;
  logic              busy;
  logic              done;

  int nchecks = 0;
  int nfail   = 0;
  int ncyc    = 0;
  int wp      = 0;
  int ap      = 0;
  int dn      = 0;

  pe_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nvec(nvec),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .wwrite(wwrite), .win(win), .active(active),
    .datain(datain), .sumin(sumin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // start is sampled at the first edge; ncyc counts edges after it
  task automatic launch(input logic [NVEC_W-1:0] n);
    start = 1'b1;
    nvec  = n;
    cyc();
    start = 1'b0;
    ncyc  = 0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      cyc();
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic load4(input logic [7:0] base);
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = base + 8'(i);
      cyc();
    end
    w_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      wp += int'(wwrite);
      ap += int'(active);
      dn += int'(done);
      chk("sumin_zero", {16'd0, sumin}, 32'd0);
      chk("no_overlap", {31'd0, wwrite && active}, 32'd0);
    end
  end

  logic [7:0] wv [4];
  logic [7:0] av [3];
  int w0, a0, d0, xf;
  logic [7:0] last_win;

  initial begin
    wv[0] = 8'h04; wv[1] = 8'h08; wv[2] = 8'h0C; wv[3] = 8'h10;
    av[0] = 8'h01; av[1] = 8'h02; av[2] = 8'h03;
    rst_n = 1'b0; start = 1'b0; nvec = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wwrite", {31'd0, wwrite}, 32'd0);
    chk("rst_win", {24'd0, win}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_datain", {24'd0, datain}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wready", {31'd0, w_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full tile, nvec=3, no bubbles
    w0 = wp; a0 = ap; d0 = dn;
    launch(7'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_wready", {31'd0, w_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_data  = wv[i];
      cyc();
      chk("t1_wwrite", {31'd0, wwrite}, 32'd1);
      chk("t1_win", {24'd0, win}, {24'd0, wv[i]});
    end
    w_valid = 1'b0;
    chk("t1_gap_wready", {31'd0, w_ready}, 32'd0);
    chk("t1_gap_aready", {31'd0, a_ready}, 32'd0);
    cyc();
    chk("t1_gap_wwrite", {31'd0, wwrite}, 32'd0);
    chk("t1_gap_active", {31'd0, active}, 32'd0);
    chk("t1_aready", {31'd0, a_ready}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      a_valid = 1'b1;
      a_data  = av[j];
      cyc();
      chk("t1_active", {31'd0, active}, 32'd1);
      chk("t1_datain", {24'd0, datain}, {24'd0, av[j]});
    end
    a_valid = 1'b0;
    chk("t1_drain_aready", {31'd0, a_ready}, 32'd0);
    wait_done(30);
    // done occupies the 13th cycle counted from the start edge
    chk("t1_done_lat", ncyc, 32'd12);
    cyc();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_wpulses", wp - w0, 32'd4);
    chk("t1_apulses", ap - a0, 32'd3);
    chk("t1_dones", dn - d0, 32'd1);

    // weight bubbles: w_valid every other cycle, data always moving
    w0 = wp; a0 = ap;
    launch(7'd1);
    xf = 0;
    last_win = win;
    for (int i = 0; i < 12 && xf < 4; i++) begin
      w_valid = (i % 2 == 0);
      w_data  = 8'h20 + 8'(i);
      cyc();
      if (i % 2 == 0) begin
        xf++;
        last_win = 8'h20 + 8'(i);
        chk("bub_wwrite_hi", {31'd0, wwrite}, 32'd1);
      end else begin
        chk("bub_wwrite_lo", {31'd0, wwrite}, 32'd0);
      end
      chk("bub_win", {24'd0, win}, {24'd0, last_win});
    end
    w_valid = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h55;
    wait_done(30);
    a_valid = 1'b0;
    chk("bub_wpulses", wp - w0, 32'd4);
    chk("bub_apulses", ap - a0, 32'd1);
    chk("bub_datain", {24'd0, datain}, 32'h55);
    cyc();

    // nvec=0: GAP goes straight to DRAIN
    a0 = ap;
    launch(7'd0);
    load4(8'h30);
    a_valid = 1'b1;
    a_data  = 8'h77;
    cyc();
    chk("n0_aready", {31'd0, a_ready}, 32'd0);
    wait_done(30);
    a_valid = 1'b0;
    chk("n0_done_lat", ncyc, 32'd9);
    chk("n0_apulses", ap - a0, 32'd0);
    cyc();

    // nvec=100 clamps to 64; start mid-stream is ignored
    a0 = ap; d0 = dn;
    launch(7'd100);
    load4(8'h40);
    a_valid = 1'b1;
    a_data  = 8'h11;
    repeat (10) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(200);
    a_valid = 1'b0;
    repeat (5) cyc();
    chk("clamp_apulses", ap - a0, 32'd64);
    chk("clamp_dones", dn - d0, 32'd1);
    chk("clamp_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of STREAM
    launch(7'd5);
    load4(8'h50);
    a_valid = 1'b1;
    a_data  = 8'h99;
    repeat (3) cyc();
    chk("pre_rst_active", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wwrite", {31'd0, wwrite}, 32'd0);
    chk("mid_rst_win", {24'd0, win}, 32'd0);
    chk("mid_rst_active", {31'd0, active}, 32'd0);
    chk("mid_rst_datain", {24'd0, datain}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_aready", {31'd0, a_ready}, 32'd0);
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
